// File: rtl/vga_clk_pkg.sv
// Shared types and constants for the multi-channel fractional clock-enable generator.
package vga_clk_pkg;

  localparam int unsigned AccWDefault = 16;
  localparam longint unsigned RefClkHz = 64'd50_000_000;

  typedef enum logic {
    StSettle = 1'b0,
    StLocked = 1'b1
  } state_e;

  // Phase increment giving f_out_hz enables from f_ref_hz with the default accumulator width.
  function automatic int unsigned inc_for(longint unsigned f_out_hz, longint unsigned f_ref_hz);
    longint unsigned scaled;
    scaled = (f_out_hz << AccWDefault) / f_ref_hz;
    return 32'(scaled);
  endfunction

  localparam int unsigned IncDefault = inc_for(64'd25_000_000, RefClkHz);

endpackage

// File: rtl/vga_phase_acc.sv
// Single-channel phase accumulator: carry out becomes a one-cycle enable and toggles clkout.
module vga_phase_acc #(
  parameter int unsigned ACC_W     = 16,
  parameter int unsigned INC_RESET = 32768
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_we_i,
  input  logic [ACC_W-1:0] inc_i,
  input  logic             clear_i,
  input  logic             run_i,
  output logic             clken_o,
  output logic             clkout_o
);

  logic [ACC_W-1:0] inc_q;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W:0]   sum;
  logic             clken_q;
  logic             clkout_q;

  always_comb begin
    sum = {1'b0, acc_q} + {1'b0, inc_q};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      inc_q    <= ACC_W'(INC_RESET);
      acc_q    <= '0;
      clken_q  <= 1'b0;
      clkout_q <= 1'b0;
    end else begin
      if (inc_we_i) begin
        inc_q <= inc_i;
      end
      // Any config write realigns every channel, so clearing wins over running.
      if (clear_i || !run_i) begin
        acc_q    <= '0;
        clken_q  <= 1'b0;
        clkout_q <= 1'b0;
      end else begin
        acc_q    <= sum[ACC_W-1:0];
        clken_q  <= sum[ACC_W];
        clkout_q <= clkout_q ^ sum[ACC_W];
      end
    end
  end

  assign clken_o  = clken_q;
  assign clkout_o = clkout_q;

endmodule

// File: rtl/vga_clken_gen.sv
// Multi-channel fractional clock-enable generator with settle/lock FSM and runtime reprogramming.
module vga_clken_gen
  import vga_clk_pkg::*;
#(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned ACC_W       = AccWDefault,
  parameter int unsigned INC_DEFAULT = IncDefault,
  parameter int unsigned LOCK_CYCLES = 16,
  parameter int unsigned CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              refclk_i,
  input  logic              rst_i,
  input  logic              cfg_we_i,
  input  logic [CH_W-1:0]   cfg_ch_i,
  input  logic [ACC_W-1:0]  cfg_inc_i,
  output logic [NUM_CH-1:0] clken_o,
  output logic [NUM_CH-1:0] clkout_o,
  output logic              locked_o
);

  localparam int unsigned CntW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(LOCK_CYCLES - 1);

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic              locked_q;
  logic              cfg_hit;
  logic              run;
  logic [NUM_CH-1:0] inc_we;

  // Writes to a channel index beyond NUM_CH are dropped without re-settling.
  always_comb begin
    cfg_hit = cfg_we_i && (32'(cfg_ch_i) < NUM_CH);
    run     = (state_q == StLocked);
    inc_we  = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      inc_we[i] = cfg_hit && (cfg_ch_i == CH_W'(i));
    end
  end

  always_ff @(posedge refclk_i) begin
    if (rst_i) begin
      state_q  <= StSettle;
      cnt_q    <= '0;
      locked_q <= 1'b0;
    end else if (cfg_hit) begin
      state_q  <= StSettle;
      cnt_q    <= '0;
      locked_q <= 1'b0;
    end else begin
      unique case (state_q)
        StSettle: begin
          if (cnt_q == CntLast) begin
            state_q  <= StLocked;
            cnt_q    <= '0;
            locked_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StLocked: begin
          locked_q <= 1'b1;
        end
        default: begin
          state_q  <= StSettle;
          cnt_q    <= '0;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

  assign locked_o = locked_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    vga_phase_acc #(
      .ACC_W    (ACC_W),
      .INC_RESET(INC_DEFAULT)
    ) u_acc (
      .clk_i   (refclk_i),
      .rst_i   (rst_i),
      .inc_we_i(inc_we[i]),
      .inc_i   (cfg_inc_i),
      .clear_i (cfg_hit),
      .run_i   (run),
      .clken_o (clken_o[i]),
      .clkout_o(clkout_o[i])
    );
  end

endmodule

// File: tb/tb_vga_clken_gen.sv
// Scoreboard bench: stimulus pushes per-cycle expectations, a negedge monitor pops and compares.
module tb_vga_clken_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_ch = '0;
  logic [15:0] cfg_inc = '0;
  logic [1:0]  clken;
  logic [1:0]  clkout;
  logic        locked;

  typedef struct {
    int         cyc;
    int         tag;
    logic       lk;
    logic [1:0] ce;
    logic [1:0] co;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  vga_clken_gen #(
    .NUM_CH     (2),
    .ACC_W      (16),
    .INC_DEFAULT(32768),
    .LOCK_CYCLES(16),
    .CH_W       (2)
  ) dut (
    .refclk_i (clk),
    .rst_i    (rst),
    .cfg_we_i (cfg_we),
    .cfg_ch_i (cfg_ch),
    .cfg_inc_i(cfg_inc),
    .clken_o  (clken),
    .clkout_o (clkout),
    .locked_o (locked)
  );

  always #10 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor
  initial forever begin
    exp_t e;
    @(negedge clk);
    while (q.size() > 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      n_vec++;
      n_bad++;
      $display("FAIL missed tag%0d cyc%0d (now %0d)", e.tag, e.cyc, cyc);
    end
    if (q.size() > 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      n_vec++;
      if ({locked, clken, clkout} !== {e.lk, e.ce, e.co}) begin
        n_bad++;
        $display("FAIL tag%0d cyc%0d got lk=%b ce=%b co=%b want lk=%b ce=%b co=%b",
                 e.tag, cyc, locked, clken, clkout, e.lk, e.ce, e.co);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic push_settle(input int tag, input int c0, input int n);
    exp_t e;
    for (int t = 0; t < n; t++) begin
      e.cyc = c0 + t; e.tag = tag; e.lk = 1'b0; e.ce = 2'b00; e.co = 2'b00;
      q.push_back(e);
    end
  endtask

  // m0/m1: hand-computed clken bit per LOCKED cycle T for ch0/ch1.
  task automatic push_win(input int tag, input int c0, input int n,
                          input logic [15:0] m0, input logic [15:0] m1);
    exp_t e;
    logic [1:0] co;
    co = 2'b00;
    for (int t = 0; t < n; t++) begin
      e.ce  = {m1[t], m0[t]};
      co    = co ^ e.ce;
      e.cyc = c0 + t; e.tag = tag; e.lk = 1'b1; e.co = co;
      q.push_back(e);
    end
  endtask

  task automatic cfg_write(input logic [1:0] ch, input logic [15:0] inc);
    cfg_we = 1'b1; cfg_ch = ch; cfg_inc = inc;
    tick();
    cfg_we = 1'b0;
  endtask

  initial begin
    int base;
    int w;
    int lk;
    int pulses;
    exp_t e;

    // Reset state and default lock
    tick();
    e.cyc = cyc; e.tag = 0; e.lk = 1'b0; e.ce = 2'b00; e.co = 2'b00;
    q.push_back(e);
    tick();
    tick();
    rst = 1'b0;
    base = cyc;
    push_settle(1, base, 16);
    push_win(1, base + 16, 16, 16'h5554, 16'h5554);
    wait_to(base + 32);

    // Integer rate on ch1
    w = cyc;
    push_settle(2, w + 1, 16);
    push_win(2, w + 17, 16, 16'h5554, 16'h1110);
    cfg_write(2'd1, 16'h4000);
    wait_to(w + 33);

    // Fractional rate on ch0 plus long-run pulse count
    w = cyc;
    lk = w + 17;
    push_settle(3, w + 1, 16);
    push_win(3, lk, 16, 16'h2490, 16'h1110);
    cfg_write(2'd0, 16'h5555);
    wait_to(lk + 1);
    pulses = 0;
    for (int i = 0; i < 65536; i++) begin
      @(negedge clk);
      pulses += int'(clken[0]);
      tick();
    end
    n_vec++;
    if (pulses != 21845) begin
      n_bad++;
      $display("FAIL pulse_count got %0d want 21845", pulses);
    end

    // Reconfigure at T=5 while locked
    w = cyc;
    lk = w + 17;
    push_settle(4, w + 1, 16);
    push_win(4, lk, 6, 16'h0010, 16'h0014);
    cfg_write(2'd1, 16'h8000);
    wait_to(lk + 5);
    push_settle(5, lk + 6, 16);
    push_win(5, lk + 22, 16, 16'h2490, 16'h1110);
    cfg_write(2'd1, 16'h4000);
    lk = lk + 22;

    // Out-of-range channel write at T=6 must be ignored
    wait_to(lk + 6);
    cfg_write(2'd3, 16'h0000);
    wait_to(lk + 16);

    // rst together with cfg_we at settle counter 7
    w = cyc;
    push_settle(6, w + 1, 8);
    cfg_write(2'd1, 16'h1234);
    wait_to(w + 8);
    rst = 1'b1; cfg_we = 1'b1; cfg_ch = 2'd0; cfg_inc = 16'h4000;
    tick();
    rst = 1'b0; cfg_we = 1'b0;
    base = cyc;
    push_settle(7, base, 16);
    push_win(7, base + 16, 16, 16'h5554, 16'h5554);
    wait_to(base + 32);

    for (int i = 0; i < 100 && q.size() > 0; i++) tick();
    if (q.size() > 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_clken_gen.md
Name: vga_clken_gen

Overview:
- Parametrised multi-channel fractional clock-enable generator for the VGA/video path.
- Runs on the single 50 MHz reference clock. Each channel produces a one-cycle enable pulse at rate inc/2^ACC_W of refclk, plus a toggled square-wave output.
- Provides a `locked` indication after a settle interval, and re-settles on any runtime reconfiguration.
- Successor to the fixed single-output PLL wrapper: channel count and rates are parametrised and programmable at runtime, and all downstream logic stays in one clock domain.

Parameters:
- NUM_CH, 2, number of independent enable channels (1..8).
- ACC_W, 16, phase-accumulator width in bits.
- INC_DEFAULT, 32768, reset increment for every channel; 0x8000 gives 25 MHz enables from 50 MHz.
- LOCK_CYCLES, 16, settle interval in cycles before `locked` asserts (>=1).
- CH_W, $clog2(NUM_CH) (min 1), width of the channel select.

Ports:
- refclk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_we  in  1  single-cycle write strobe.
- cfg_ch  in  CH_W  channel index for the write.
- cfg_inc  in  ACC_W  new increment for channel cfg_ch.
- clken  out  NUM_CH  per-channel one-cycle enable pulses.
- clkout  out  NUM_CH  per-channel square wave, toggles on each clken pulse.
- locked  out  1  high when the generator is in LOCKED.

Behaviour:
- Reset: state=SETTLE, settle counter=0, every inc[i]=INC_DEFAULT, every acc[i]=0. Outputs clken=0, clkout=0, locked=0.
- FSM SETTLE:
  - Counter increments each cycle.
  - When counter==LOCK_CYCLES-1, go to LOCKED.
  - While in SETTLE: acc held at 0, clken=0, clkout=0.
- FSM LOCKED:
  - locked=1, registered: high from the first LOCKED cycle (cycle LOCK_CYCLES after reset release).
  - Accumulators run.
- Accumulation, per channel, each LOCKED cycle T (T=0 is the first LOCKED cycle, acc=0 at T=0):
  - {carry, acc_next} = acc + inc, computed at ACC_W+1 bits.
  - acc wraps modulo 2^ACC_W.
- Enable and square-wave outputs:
  - clken[i] is registered: high in cycle T+1 iff carry occurred in cycle T.
  - clkout[i] toggles in the same cycle clken[i] is high.
- inc=0: the channel never pulses and clkout stays 0. Lock still proceeds.
- Maximum increment is 2^ACC_W-1, giving a pulse on nearly every cycle. There is no pulse-rate check.
- Config write, cfg_we=1 with cfg_ch<NUM_CH:
  - inc[cfg_ch] := cfg_inc.
  - Next cycle: state=SETTLE, counter=0, locked=0, all acc cleared, all clken=0, all clkout=0. All channels re-align.
  - The write takes effect whether the FSM is in SETTLE (settle restarts) or LOCKED.
- cfg_we with cfg_ch>=NUM_CH: ignored entirely; no state change and no re-settle.
- Simultaneous rst and cfg_we: rst wins. Increments return to INC_DEFAULT.
- rst mid-operation: full reset on the next edge. Pulses already issued are not completed.
- Phase relation: all channels share T=0, so channels with integer-related increments stay phase-aligned after every (re)lock.

Decomposition:
- Shared package vga_clk_pkg holds:
  - FSM state enum {SETTLE, LOCKED};
  - ACC_W default;
  - INC_DEFAULT;
  - helper function inc_for(f_out_hz, f_ref_hz) returning the increment constant.
- One natural sub-module, vga_phase_acc: a single-channel accumulator with inc register, carry-to-clken register and clkout toggle. It has clear and run inputs from the top FSM.
- Top module holds the FSM, settle counter, config decode and a generate loop over channels.

Test Plan:
- Reset defaults, NUM_CH=2, LOCK_CYCLES=16: release rst at cycle 0 -> locked=0 for cycles 0..15 and 1 from cycle 16. Both clken high at T=2,4,6,…; clkout toggles at each pulse.
- Integer rate: write ch1 inc=0x4000 -> after 16-cycle re-settle, ch1 clken at T=4,8,12 while ch0 stays at T=2,4,6. Rising edges coincide at T=4 and T=8.
- Fractional rate: ch0 inc=0x5555 -> clken at T=4,7,10,13. Over 65536 LOCKED cycles the pulse count is exactly 21845.
- Reconfigure while LOCKED at T=5 -> next cycle locked=0, clken=0, clkout=0. locked reasserts exactly 16 cycles later and acc restarts from 0.
- Invalid channel: cfg_we with cfg_ch=3 (NUM_CH=2) while locked -> no change; locked stays 1 and the pulse pattern is uninterrupted.
- rst asserted mid-SETTLE at counter=7, together with cfg_we -> all outputs 0, inc back to 0x8000, and lock occurs 16 cycles after rst release.
